// File: rtl/guess_checker.sv
// Guessing-game control stage. It latches a secret from the LFSR on start,
// grades each guess as high, low or correct, counts attempts, and ends the
// round on a win or when the attempt limit is reached. Every output comes
// straight from a register.
module guess_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_TRIES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rand_in,
    input  logic             start,
    input  logic [WIDTH-1:0] guess,
    input  logic             guess_valid,
    output logic             too_high,
    output logic             too_low,
    output logic             correct,
    output logic             game_over,
    output logic [3:0]       attempts,
    output logic [WIDTH-1:0] secret_out,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StWin  = 2'd2,
        StLose = 2'd3
    } state_e;

    localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] secret_q, secret_d;
    logic [3:0]       attempts_q, attempts_d;
    logic             too_high_q, too_high_d;
    logic             too_low_q, too_low_d;
    logic             correct_q, correct_d;
    logic             game_over_q, game_over_d;
    logic [WIDTH-1:0] secret_out_q, secret_out_d;
    logic [3:0]       attempts_inc;

    assign attempts_inc = attempts_q + 4'd1;

    // Next-state logic: start opens a round from any non-playing state,
    // guesses are graded only while playing.
    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        attempts_d  = attempts_q;
        too_high_d  = too_high_q;
        too_low_d   = too_low_q;
        correct_d   = correct_q;
        game_over_d = game_over_q;

        unique case (state_q)
            StIdle, StWin, StLose: begin
                // A guess arriving with start is dropped and never counted.
                if (start) begin
                    state_d     = StPlay;
                    secret_d    = rand_in;
                    attempts_d  = 4'd0;
                    too_high_d  = 1'b0;
                    too_low_d   = 1'b0;
                    correct_d   = 1'b0;
                    game_over_d = 1'b0;
                end
            end
            StPlay: begin
                // start is ignored here; only rst can abandon a round.
                if (guess_valid) begin
                    attempts_d = attempts_inc;
                    too_high_d = (guess > secret_q);
                    too_low_d  = (guess < secret_q);
                    correct_d  = (guess == secret_q);
                    if (guess == secret_q) begin
                        state_d     = StWin;
                        game_over_d = 1'b1;
                    end else if (attempts_inc == MaxTries) begin
                        state_d     = StLose;
                        game_over_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // The secret is revealed only once the round is over.
        secret_out_d = game_over_d ? secret_d : '0;
    end

    // State register with synchronous reset that discards any round in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            secret_q     <= '0;
            attempts_q   <= 4'd0;
            too_high_q   <= 1'b0;
            too_low_q    <= 1'b0;
            correct_q    <= 1'b0;
            game_over_q  <= 1'b0;
            secret_out_q <= '0;
        end else begin
            state_q      <= state_d;
            secret_q     <= secret_d;
            attempts_q   <= attempts_d;
            too_high_q   <= too_high_d;
            too_low_q    <= too_low_d;
            correct_q    <= correct_d;
            game_over_q  <= game_over_d;
            secret_out_q <= secret_out_d;
        end
    end

    assign too_high   = too_high_q;
    assign too_low    = too_low_q;
    assign correct    = correct_q;
    assign game_over  = game_over_q;
    assign attempts   = attempts_q;
    assign secret_out = secret_out_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker. Expected output words are pushed to
// a scoreboard queue as stimulus is driven and popped after the clock edge.
module tb_guess_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rand_in = 4'd0;
    logic       start = 1'b0;
    logic [3:0] guess = 4'd0;
    logic       guess_valid = 1'b0;
    logic       too_high, too_low, correct, game_over;
    logic [3:0] attempts;
    logic [3:0] secret_out;
    logic [1:0] state_out;

    int checks = 0;
    int errors = 0;

    // {state, attempts, too_high, too_low, correct, game_over, secret_out}
    logic [13:0] sb[$];
    logic [13:0] ev;
    logic [13:0] obs;

    assign obs = {state_out, attempts, too_high, too_low, correct, game_over, secret_out};

    guess_checker #(.WIDTH(4), .MAX_TRIES(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_in    (rand_in),
        .start      (start),
        .guess      (guess),
        .guess_valid(guess_valid),
        .too_high   (too_high),
        .too_low    (too_low),
        .correct    (correct),
        .game_over  (game_over),
        .attempts   (attempts),
        .secret_out (secret_out),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic [1:0] st, input logic [3:0] at,
                                       input logic th, input logic tl, input logic co,
                                       input logic go, input logic [3:0] so);
        return {st, at, th, tl, co, go, so};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        sb.push_back(mk(2'd0, 4'd0, 0, 0, 0, 0, 4'd0));
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", obs, ev);
        end
        // Guess in IDLE must be ignored.
        rst = 1'b0;
        guess = 4'd3;
        guess_valid = 1'b1;
        sb.push_back(mk(2'd0, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        guess_valid = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL idle_guess obs=%h exp=%h", obs, ev);
        end
    endtask

    task automatic test_start_latch();
        rand_in = 4'd9;
        start = 1'b1;
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        start = 1'b0;
        rand_in = 4'd4;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL start_latch obs=%h exp=%h", obs, ev);
        end
        // Idle PLAY cycle holds everything.
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL play_hold obs=%h exp=%h", obs, ev);
        end
    endtask

    task automatic test_compare();
        logic [3:0]  g[3];
        logic [13:0] e[3];
        g = '{4'd12, 4'd2, 4'd9};
        e = '{mk(2'd1, 4'd1, 1, 0, 0, 0, 4'd0),
              mk(2'd1, 4'd2, 0, 1, 0, 0, 4'd0),
              mk(2'd2, 4'd3, 0, 0, 1, 1, 4'd9)};
        for (int i = 0; i < 3; i++) begin
            guess = g[i];
            guess_valid = 1'b1;
            sb.push_back(e[i]);
            step();
            guess_valid = 1'b0;
            ev = sb.pop_front();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL compare[%0d] obs=%h exp=%h", i, obs, ev);
            end
        end
        // Guess in WIN is ignored.
        guess = 4'd3;
        guess_valid = 1'b1;
        sb.push_back(mk(2'd2, 4'd3, 0, 0, 1, 1, 4'd9));
        step();
        guess_valid = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL win_hold obs=%h exp=%h", obs, ev);
        end
    endtask

    task automatic test_lose();
        rand_in = 4'd7;
        start = 1'b1;
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        start = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL lose_start obs=%h exp=%h", obs, ev);
        end
        for (int i = 1; i <= 6; i++) begin
            guess = (i == 6) ? 4'd9 : 4'(i);
            guess_valid = 1'b1;
            if (i < 5) sb.push_back(mk(2'd1, 4'(i), 0, 1, 0, 0, 4'd0));
            else       sb.push_back(mk(2'd3, 4'd5, 0, 1, 0, 1, 4'd7));
            step();
            guess_valid = 1'b0;
            ev = sb.pop_front();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL lose_guess[%0d] obs=%h exp=%h", i, obs, ev);
            end
        end
    endtask

    task automatic test_last_try_win();
        logic [3:0]  g[5];
        logic [13:0] e[5];
        g = '{4'd8, 4'd9, 4'd1, 4'd2, 4'd7};
        e = '{mk(2'd1, 4'd1, 1, 0, 0, 0, 4'd0),
              mk(2'd1, 4'd2, 1, 0, 0, 0, 4'd0),
              mk(2'd1, 4'd3, 0, 1, 0, 0, 4'd0),
              mk(2'd1, 4'd4, 0, 1, 0, 0, 4'd0),
              mk(2'd2, 4'd5, 0, 0, 1, 1, 4'd7)};
        // Restart straight from LOSE.
        rand_in = 4'd7;
        start = 1'b1;
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        start = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL restart_from_lose obs=%h exp=%h", obs, ev);
        end
        for (int i = 0; i < 5; i++) begin
            guess = g[i];
            guess_valid = 1'b1;
            sb.push_back(e[i]);
            step();
            guess_valid = 1'b0;
            ev = sb.pop_front();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL last_try[%0d] obs=%h exp=%h", i, obs, ev);
            end
        end
    endtask

    task automatic test_collision();
        // From WIN: start beats guess, guess not counted.
        rand_in = 4'd6;
        guess = 4'd6;
        start = 1'b1;
        guess_valid = 1'b1;
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL collide_win obs=%h exp=%h", obs, ev);
        end
        // In PLAY: guess processed, start ignored (secret stays 6).
        rand_in = 4'd1;
        guess = 4'd3;
        sb.push_back(mk(2'd1, 4'd1, 0, 1, 0, 0, 4'd0));
        step();
        start = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL collide_play obs=%h exp=%h", obs, ev);
        end
        guess = 4'd6;
        sb.push_back(mk(2'd2, 4'd2, 0, 0, 1, 1, 4'd6));
        step();
        guess_valid = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL collide_secret obs=%h exp=%h", obs, ev);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] e[6];
        e = '{mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0),
              mk(2'd1, 4'd1, 0, 1, 0, 0, 4'd0),
              mk(2'd1, 4'd2, 1, 0, 0, 0, 4'd0),
              mk(2'd1, 4'd2, 1, 0, 0, 0, 4'd0),
              mk(2'd0, 4'd0, 0, 0, 0, 0, 4'd0),
              mk(2'd0, 4'd0, 0, 0, 0, 0, 4'd0)};
        for (int i = 0; i < 6; i++) begin
            start = 1'b0;
            guess_valid = 1'b0;
            rst = 1'b0;
            case (i)
                0: begin rand_in = 4'd10; start = 1'b1; end
                1: begin guess = 4'd1; guess_valid = 1'b1; end
                2: begin guess = 4'd15; guess_valid = 1'b1; end
                3: begin rand_in = 4'd2; start = 1'b1; end
                4: rst = 1'b1;
                default: begin rst = 1'b1; start = 1'b1; rand_in = 4'd5; end
            endcase
            sb.push_back(e[i]);
            step();
            ev = sb.pop_front();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL reset_mid[%0d] obs=%h exp=%h", i, obs, ev);
            end
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_zero_secret();
        rand_in = 4'd0;
        start = 1'b1;
        sb.push_back(mk(2'd1, 4'd0, 0, 0, 0, 0, 4'd0));
        step();
        start = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL zero_start obs=%h exp=%h", obs, ev);
        end
        guess = 4'd0;
        guess_valid = 1'b1;
        sb.push_back(mk(2'd2, 4'd1, 0, 0, 1, 1, 4'd0));
        step();
        guess_valid = 1'b0;
        ev = sb.pop_front();
        checks++;
        if (obs !== ev) begin
            errors++;
            $display("FAIL zero_win obs=%h exp=%h", obs, ev);
        end
    endtask

    initial begin
        test_reset();
        test_start_latch();
        test_compare();
        test_lose();
        test_last_try_win();
        test_collision();
        test_reset_mid();
        test_zero_secret();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Game-control stage directly downstream of the 4-bit LFSR random source.
- On a start request, samples the LFSR output as the secret number.
- Accepts player guesses, flags each one as too high, too low or correct, and counts attempts.
- Ends the round on a win or when the attempt limit is reached; feeds display/LED logic.

Parameters:
- WIDTH, 4, bit width of the random value, secret and guess.
- MAX_TRIES, 5, guesses allowed per round (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rand_in  input  WIDTH  free-running LFSR output.
- start  input  1  single-cycle pulse; begins a new round.
- guess  input  WIDTH  player guess value.
- guess_valid  input  1  single-cycle pulse; guess is valid this cycle.
- too_high  output  1  last guess > secret.
- too_low  output  1  last guess < secret.
- correct  output  1  last guess == secret.
- game_over  output  1  round finished (WIN or LOSE).
- attempts  output  4  guesses consumed this round.
- secret_out  output  WIDTH  secret, shown only when game_over=1, else 0.
- state_out  output  2  current state encoding.

Behaviour:
- All outputs and internal registers are registered. No combinational path from any input to any output.
- Reset (rst=1 at a clock edge), which overrides everything:
  - state=IDLE.
  - secret=0, attempts=0.
  - too_high, too_low, correct and game_over = 0.
  - secret_out=0.
- Reset mid-round discards the round entirely.
- State encoding: IDLE=0, PLAY=1, WIN=2, LOSE=3.
- IDLE:
  - guess_valid is ignored.
  - On start: next edge sets secret=rand_in (the value present in the start cycle), attempts=0, flags cleared, state=PLAY.
- PLAY, on guess_valid, all updated at the next edge (latency 1 cycle from guess_valid to flags):
  - attempts = attempts+1.
  - Exactly one of too_high, too_low, correct is set, from an unsigned compare of guess vs secret; the other two are cleared.
- PLAY transitions:
  - guess == secret: state=WIN, game_over=1.
  - guess != secret and attempts+1 == MAX_TRIES: state=LOSE, game_over=1. The too_high/too_low flag for the final guess is still shown.
  - Otherwise: stay in PLAY.
- PLAY cycles without guess_valid: flags hold their last values.
- start in PLAY is ignored; a round cannot be abandoned except by rst.
- WIN / LOSE:
  - Outputs hold; guess_valid is ignored.
  - secret_out = secret while game_over=1.
  - start behaves as in IDLE: new secret latched from rand_in, attempts=0, flags, game_over and secret_out cleared, state=PLAY.
- Simultaneous start and guess_valid:
  - In IDLE/WIN/LOSE, start wins and the guess is discarded; it does not count as an attempt.
  - In PLAY, the guess is processed and start is ignored.
- attempts never exceeds MAX_TRIES. It is not incremented in any state other than PLAY.
- A secret of 0 is accepted as-is; no filtering of rand_in.
- A correct guess on the final allowed attempt gives WIN, not LOSE.

Test Plan:
- Reset/idle:
  - Stimulus: rst high 2 cycles, then guess_valid pulse with guess=3.
  - Required: all outputs 0, state_out=0; the guess is ignored and attempts stays 0.
- Start latch:
  - Stimulus: rand_in=9, start pulse.
  - Required: next cycle state_out=1, attempts=0, secret_out=0. rand_in then changes to 4 with no effect on the internal secret, confirmed by later compares.
- Compare:
  - Stimulus: secret=9; guesses 12, 2, 9 on separate pulses.
  - Required, one cycle after each pulse:
    - 12: too_high=1, attempts=1.
    - 2: too_low=1, attempts=2.
    - 9: correct=1, game_over=1, state_out=2, secret_out=9.
- Lose path:
  - Stimulus: MAX_TRIES=5, secret=7; guesses 1, 2, 3, 4, 5.
  - Required: attempts=5, too_low=1, game_over=1, state_out=3, secret_out=7. A sixth guess_valid changes nothing.
- Last-try win:
  - Stimulus: secret=7; four wrong guesses, then guess=7.
  - Required: state_out=2 (WIN), attempts=5.
- Restart / collision / reset mid-round:
  - From WIN, start and guess_valid in the same cycle with rand_in=6: required state PLAY, attempts=0, secret=6.
  - rst asserted mid-round after 2 attempts: required all outputs 0 and state IDLE on the next edge.
